trigger_window_gen: RTL and testbench

- Upstream stage of the channel-enable path in the sTGC TDS data logger, on the clk160 domain.
- Converts a raw external trigger into a gated acquisition window:
  - `trigger` gates each channel's `enable` in the channel deserializer block.
  - `debug_enable`, `cycle_tick` and `trigger_index` go to readout_control for event framing.
- With the trigger function disabled, the block holds the bypass state: `trigger` = 1 and `debug_enable` = 1 continuously.

---
 rtl/trigger_window_gen_pkg.sv | 21 ++
 rtl/trigger_window_gen_if.sv | 27 ++
 rtl/sync_edge_detect.sv | 26 ++
 rtl/trigger_window_gen.sv | 100 ++++++++++
 tb/tb_trigger_window_gen.sv | 277 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/trigger_window_gen_pkg.sv
// trigger_pkg: FSM encoding and default sizing shared by the trigger window path.
package trigger_pkg;

    localparam int DEF_WIDTH_W     = 10;
    localparam int DEF_INDEX_W     = 8;
    localparam int DEF_SYNC_STAGES = 2;
    localparam int DEF_HOLDOFF     = 4;

    typedef enum logic [1:0] {
        ST_BYPASS,
        ST_IDLE,
        ST_OPEN,
        ST_CLOSE
    } state_t;

    // One down-counter times both the window and the holdoff, so it must fit either.
    function automatic int cnt_width(input int width_w, input int holdoff);
        return (width_w > $clog2(holdoff + 1)) ? width_w : $clog2(holdoff + 1);
    endfunction

endpackage

// File: rtl/trigger_window_gen_if.sv
// trigger_window_if: trigger input, window control and event-framing outputs.
interface trigger_window_if
    import trigger_pkg::*;
#(
    parameter int WIDTH_W = DEF_WIDTH_W,
    parameter int INDEX_W = DEF_INDEX_W
);

    logic               trigger_in;
    logic [WIDTH_W-1:0] trigger_width;
    logic               enable_trigger;
    logic               trigger;
    logic [INDEX_W-1:0] trigger_index;
    logic               cycle_tick;
    logic               debug_enable;

    modport master (
        output trigger_in, trigger_width, enable_trigger,
        input  trigger, trigger_index, cycle_tick, debug_enable
    );

    modport slave (
        input  trigger_in, trigger_width, enable_trigger,
        output trigger, trigger_index, cycle_tick, debug_enable
    );

endinterface

// File: rtl/sync_edge_detect.sv
// sync_edge_detect: multi-flop synchronizer for an async input plus rising-edge detect.
module sync_edge_detect #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic rise
);

    logic [STAGES-1:0] sync_q;
    logic              prev_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d};
            prev_q <= sync_q[STAGES-1];
        end
    end

    assign rise = sync_q[STAGES-1] & ~prev_q;

endmodule

// File: rtl/trigger_window_gen.sv
// trigger_window_gen: turns a raw external trigger into a fixed-length acquisition window.
module trigger_window_gen
    import trigger_pkg::*;
#(
    parameter int WIDTH_W     = DEF_WIDTH_W,
    parameter int INDEX_W     = DEF_INDEX_W,
    parameter int SYNC_STAGES = DEF_SYNC_STAGES,
    parameter int HOLDOFF     = DEF_HOLDOFF
) (
    input logic            clk,
    input logic            reset,
    trigger_window_if.slave tw
);

    localparam int CNT_W = cnt_width(WIDTH_W, HOLDOFF);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [INDEX_W-1:0] idx_q, idx_d;
    logic               trig_q, trig_d;
    logic               dbg_q, dbg_d;
    logic               tick_q, tick_d;
    logic               rise;

    sync_edge_detect #(.STAGES(SYNC_STAGES)) u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (tw.trigger_in),
        .rise  (rise)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            trig_q  <= 1'b0;
            dbg_q   <= 1'b0;
            tick_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            trig_q  <= trig_d;
            dbg_q   <= dbg_d;
            tick_q  <= tick_d;
        end
    end

    // Outputs are computed for the next cycle and registered alongside the state.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        trig_d  = 1'b0;
        dbg_d   = 1'b0;
        tick_d  = 1'b0;
        if (!tw.enable_trigger) begin
            state_d = ST_BYPASS;
            trig_d  = 1'b1;
            dbg_d   = 1'b1;
        end else begin
            case (state_q)
                ST_BYPASS: state_d = ST_IDLE;
                ST_IDLE: begin
                    if (rise && tw.trigger_width != '0) begin
                        state_d = ST_OPEN;
                        cnt_d   = CNT_W'(tw.trigger_width);
                        trig_d  = 1'b1;
                        dbg_d   = 1'b1;
                    end
                end
                ST_OPEN: begin
                    dbg_d = 1'b1;
                    if (cnt_q <= CNT_W'(1)) begin
                        state_d = ST_CLOSE;
                        cnt_d   = CNT_W'(HOLDOFF);
                        tick_d  = 1'b1;
                        idx_d   = idx_q + INDEX_W'(1);
                    end else begin
                        cnt_d  = cnt_q - CNT_W'(1);
                        trig_d = 1'b1;
                    end
                end
                ST_CLOSE: begin
                    state_d = (cnt_q <= CNT_W'(1)) ? ST_IDLE : ST_CLOSE;
                    cnt_d   = (cnt_q <= CNT_W'(1)) ? cnt_q : cnt_q - CNT_W'(1);
                    dbg_d   = cnt_q > CNT_W'(1);
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    assign tw.trigger       = trig_q;
    assign tw.debug_enable  = dbg_q;
    assign tw.cycle_tick    = tick_q;
    assign tw.trigger_index = idx_q;

endmodule

// File: tb/tb_trigger_window_gen.sv
// tb_trigger_window_gen: randomized and directed checks against a window-schedule reference model.
module tb_trigger_window_gen;

    localparam int N = 2;
    localparam int H = 4;

    logic clk;
    logic reset;

    trigger_window_if #(.WIDTH_W(10), .INDEX_W(8)) tw ();

    trigger_window_gen #(
        .WIDTH_W(10), .INDEX_W(8), .SYNC_STAGES(N), .HOLDOFF(H)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .tw    (tw)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    // Reference model: the window is a schedule of edge numbers (start, close, idle),
    // derived from the sampled trigger_in history rather than from any state encoding.
    bit         hist[$];
    int         e_cnt, ws, ww, free_at;
    bit         have_win, in_bypass;
    logic       m_trig, m_dbg, m_tick;
    logic [7:0] m_idx;

    task automatic model_reset();
        hist = {};
        for (int i = 0; i <= N; i++) hist.push_back(1'b0);
        e_cnt = 0; have_win = 0; in_bypass = 0; free_at = 1;
        m_trig = 0; m_dbg = 0; m_tick = 0; m_idx = 0;
    endtask

    task automatic tick();
        bit rise;
        @(posedge clk);
        e_cnt++;
        hist.push_back(tw.trigger_in);
        if (hist.size() > N + 2) void'(hist.pop_front());
        rise = hist[hist.size()-1-N] && !hist[hist.size()-2-N];
        m_tick = 0;
        if (!tw.enable_trigger) begin
            in_bypass = 1; have_win = 0; m_trig = 1; m_dbg = 1;
        end else if (in_bypass) begin
            in_bypass = 0; free_at = e_cnt + 1; m_trig = 0; m_dbg = 0;
        end else if (have_win) begin
            m_trig = e_cnt < ws + ww;
            m_tick = e_cnt == ws + ww;
            m_dbg  = e_cnt < ws + ww + H;
            if (m_tick) m_idx++;
            if (e_cnt == ws + ww + H) begin have_win = 0; free_at = e_cnt + 1; end
        end else if (e_cnt >= free_at && rise && tw.trigger_width != 0) begin
            have_win = 1; ws = e_cnt; ww = int'(tw.trigger_width); m_trig = 1; m_dbg = 1;
        end else begin
            m_trig = 0; m_dbg = 0;
        end
        #1;
    endtask

    task automatic test_reset();
        reset = 1; tw.enable_trigger = 0; tw.trigger_in = 0; tw.trigger_width = 10'd5;
        #3;
        vectors++;
        if ({tw.trigger, tw.debug_enable, tw.cycle_tick, tw.trigger_index} !== 11'b0) begin
            miscompares++;
            $display("FAIL reset_values got=%b_%b_%b_%0d exp=0_0_0_0", tw.trigger, tw.debug_enable, tw.cycle_tick, tw.trigger_index);
        end
        repeat (3) @(posedge clk);
        @(negedge clk); reset = 0; model_reset();
        for (int k = 1; k <= 8; k++) begin
            tick();
            vectors++;
            if ({tw.trigger, tw.debug_enable, tw.cycle_tick, tw.trigger_index} !== {3'b110, 8'd0}) begin
                miscompares++;
                $display("FAIL bypass_after_reset k=%0d got=%b_%b_%b_%0d exp=1_1_0_0", k, tw.trigger, tw.debug_enable, tw.cycle_tick, tw.trigger_index);
            end
        end
    endtask

    task automatic test_single_window();
        int first_hi, highs, trig_fall, dbg_fall, ticks;
        first_hi = 0; highs = 0; trig_fall = 0; dbg_fall = 0; ticks = 0;
        tw.enable_trigger = 1; tw.trigger_width = 10'd5;
        repeat (3) tick();
        tw.trigger_in = 1;
        for (int k = 1; k <= 20; k++) begin
            tick();
            if (k == 3) tw.trigger_in = 0;
            vectors++;
            if ({tw.trigger, tw.debug_enable, tw.cycle_tick, tw.trigger_index} !== {m_trig, m_dbg, m_tick, m_idx}) begin
                miscompares++;
                $display("FAIL single_model k=%0d got=%b_%b_%b_%0d exp=%b_%b_%b_%0d", k, tw.trigger, tw.debug_enable, tw.cycle_tick, tw.trigger_index, m_trig, m_dbg, m_tick, m_idx);
            end
            if (tw.trigger && first_hi == 0) first_hi = k;
            if (tw.trigger) highs++;
            if (tw.cycle_tick) ticks++;
            if (first_hi != 0 && !tw.trigger && trig_fall == 0) trig_fall = k;
            if (first_hi != 0 && !tw.debug_enable && dbg_fall == 0) dbg_fall = k;
        end
        vectors++;
        if (first_hi !== 3) begin miscompares++; $display("FAIL latency got=%0d exp=3", first_hi); end
        vectors++;
        if (highs !== 5) begin miscompares++; $display("FAIL window_len got=%0d exp=5", highs); end
        vectors++;
        if (ticks !== 1) begin miscompares++; $display("FAIL tick_count got=%0d exp=1", ticks); end
        vectors++;
        if (dbg_fall - trig_fall !== H) begin miscompares++; $display("FAIL holdoff got=%0d exp=%0d", dbg_fall - trig_fall, H); end
        vectors++;
        if (tw.trigger_index !== 8'd1) begin miscompares++; $display("FAIL first_index got=%0d exp=1", tw.trigger_index); end
    endtask

    task automatic test_back_to_back();
        int ticks;
        logic [7:0] idx0;
        bit pat [12] = '{1, 1, 0, 0, 1, 1, 0, 0, 1, 1, 0, 0};
        ticks = 0; idx0 = m_idx;
        tw.trigger_width = 10'd6;
        for (int k = 0; k < 28; k++) begin
            tw.trigger_in = (k < 12) ? pat[k] : 1'b0;
            tick();
            vectors++;
            if ({tw.trigger, tw.debug_enable, tw.cycle_tick, tw.trigger_index} !== {m_trig, m_dbg, m_tick, m_idx}) begin
                miscompares++;
                $display("FAIL b2b_model k=%0d got=%b_%b_%b_%0d exp=%b_%b_%b_%0d", k, tw.trigger, tw.debug_enable, tw.cycle_tick, tw.trigger_index, m_trig, m_dbg, m_tick, m_idx);
            end
            if (tw.cycle_tick) ticks++;
        end
        vectors++;
        if (ticks !== 1) begin miscompares++; $display("FAIL b2b_windows got=%0d exp=1", ticks); end
        vectors++;
        if (tw.trigger_index !== idx0 + 8'd1) begin miscompares++; $display("FAIL b2b_index got=%0d exp=%0d", tw.trigger_index, idx0 + 8'd1); end
    endtask

    task automatic test_width_change();
        int highs, ticks;
        logic [7:0] idx0;
        highs = 0; ticks = 0; idx0 = m_idx;
        tw.trigger_width = 10'd0;
        for (int k = 0; k < 14; k++) begin
            tw.trigger_in = k < 2;
            tick();
            vectors++;
            if ({tw.trigger, tw.debug_enable, tw.cycle_tick, tw.trigger_index} !== {m_trig, m_dbg, m_tick, m_idx}) begin
                miscompares++;
                $display("FAIL zero_model k=%0d got=%b_%b_%b_%0d exp=%b_%b_%b_%0d", k, tw.trigger, tw.debug_enable, tw.cycle_tick, tw.trigger_index, m_trig, m_dbg, m_tick, m_idx);
            end
            if (tw.trigger) highs++;
            if (tw.cycle_tick) ticks++;
        end
        vectors++;
        if (highs !== 0 || ticks !== 0 || tw.trigger_index !== idx0) begin
            miscompares++;
            $display("FAIL zero_width got=%0d/%0d/%0d exp=0/0/%0d", highs, ticks, tw.trigger_index, idx0);
        end
        for (int p = 0; p < 2; p++) begin
            highs = 0;
            tw.trigger_width = (p == 0) ? 10'd7 : 10'd3;
            for (int k = 0; k < 20; k++) begin
                tw.trigger_in = k < 2;
                if (p == 0 && k == 5) tw.trigger_width = 10'd3;
                tick();
                vectors++;
                if ({tw.trigger, tw.debug_enable, tw.cycle_tick, tw.trigger_index} !== {m_trig, m_dbg, m_tick, m_idx}) begin
                    miscompares++;
                    $display("FAIL change_model p=%0d k=%0d got=%b_%b_%b_%0d exp=%b_%b_%b_%0d", p, k, tw.trigger, tw.debug_enable, tw.cycle_tick, tw.trigger_index, m_trig, m_dbg, m_tick, m_idx);
                end
                if (tw.trigger) highs++;
            end
            vectors++;
            if (highs !== ((p == 0) ? 7 : 3)) begin
                miscompares++;
                $display("FAIL width_latch p=%0d got=%0d exp=%0d", p, highs, (p == 0) ? 7 : 3);
            end
        end
    endtask

    task automatic test_wrap_and_bypass();
        int wins, budget, h, g;
        bit saw_wrap;
        logic [7:0] idx0, held;
        wins = 0; budget = 0; saw_wrap = 0; idx0 = m_idx;
        while (wins < 256 && budget < 6000) begin
            h = $urandom_range(1, 3); g = $urandom_range(9, 12);
            tw.trigger_width = 10'($urandom_range(1, 3));
            for (int i = 0; i < h + g; i++) begin
                tw.trigger_in = i < h;
                tick();
                budget++;
                vectors++;
                if ({tw.trigger, tw.debug_enable, tw.cycle_tick, tw.trigger_index} !== {m_trig, m_dbg, m_tick, m_idx}) begin
                    miscompares++;
                    $display("FAIL wrap_model w=%0d got=%b_%b_%b_%0d exp=%b_%b_%b_%0d", wins, tw.trigger, tw.debug_enable, tw.cycle_tick, tw.trigger_index, m_trig, m_dbg, m_tick, m_idx);
                end
                if (tw.cycle_tick) begin
                    wins++;
                    if (tw.trigger_index == 8'd0) saw_wrap = 1;
                end
            end
        end
        vectors++;
        if (wins !== 256 || !saw_wrap || tw.trigger_index !== idx0) begin
            miscompares++;
            $display("FAIL index_wrap got=%0d/%0d/%0d exp=256/1/%0d", wins, saw_wrap, tw.trigger_index, idx0);
        end
        tw.trigger_width = 10'd10; tw.trigger_in = 1;
        repeat (4) tick();
        tw.trigger_in = 0; tw.enable_trigger = 0; held = m_idx;
        for (int k = 0; k < 12; k++) begin
            tick();
            vectors++;
            if ({tw.trigger, tw.debug_enable, tw.cycle_tick, tw.trigger_index} !== {3'b110, held}) begin
                miscompares++;
                $display("FAIL bypass_mid_open k=%0d got=%b_%b_%b_%0d exp=1_1_0_%0d", k, tw.trigger, tw.debug_enable, tw.cycle_tick, tw.trigger_index, held);
            end
        end
        tw.enable_trigger = 1;
        tick();
        vectors++;
        if ({tw.trigger, tw.debug_enable, tw.cycle_tick} !== 3'b000) begin
            miscompares++;
            $display("FAIL bypass_exit got=%b_%b_%b exp=0_0_0", tw.trigger, tw.debug_enable, tw.cycle_tick);
        end
    endtask

    task automatic test_reset_mid_window();
        tw.trigger_width = 10'd8; tw.trigger_in = 1;
        repeat (2) tick();
        tw.trigger_in = 0;
        repeat (3) tick();
        #2 reset = 1;
        #1;
        vectors++;
        if ({tw.trigger, tw.debug_enable, tw.cycle_tick, tw.trigger_index} !== 11'b0) begin
            miscompares++;
            $display("FAIL async_reset got=%b_%b_%b_%0d exp=0_0_0_0", tw.trigger, tw.debug_enable, tw.cycle_tick, tw.trigger_index);
        end
        model_reset();
        @(negedge clk); reset = 0;
        tw.trigger_width = 10'd3;
        for (int k = 0; k < 16; k++) begin
            tw.trigger_in = (k >= 2 && k < 4);
            tick();
            vectors++;
            if ({tw.trigger, tw.debug_enable, tw.cycle_tick, tw.trigger_index} !== {m_trig, m_dbg, m_tick, m_idx}) begin
                miscompares++;
                $display("FAIL post_reset_model k=%0d got=%b_%b_%b_%0d exp=%b_%b_%b_%0d", k, tw.trigger, tw.debug_enable, tw.cycle_tick, tw.trigger_index, m_trig, m_dbg, m_tick, m_idx);
            end
        end
        vectors++;
        if (tw.trigger_index !== 8'd1) begin miscompares++; $display("FAIL post_reset_index got=%0d exp=1", tw.trigger_index); end
    endtask

    initial begin
        test_reset();
        test_single_window();
        test_back_to_back();
        test_width_change();
        test_wrap_and_bypass();
        test_reset_mid_window();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL timeout reached before bench completed");
        $fatal(1);
    end

endmodule
